uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered serial transmitter for the processor's memory-mapped UART path. Accepts bytes through a ready/valid handshake into a small FIFO and serialises them onto the TX line as 8N1 frames at a fixed baud rate. It sits between the UART address decoder's write port and the board serial output pin. Software can queue several bytes without polling DataInReady before each one.

## Interface
- ClockFreq, 50_000_000: system clock frequency in Hz.
- BaudRate, 115_200: line rate in bits/s.
- Depth, 8: FIFO depth in bytes. Must be a power of two and at least 2.
- Clock  input  1  system clock. All state changes on the rising edge.
- Reset  input  1  reset. One clock; reset is asynchronous and active-low.
- DataIn  input  8  byte to transmit.
- DataInValid  input  1  DataIn is valid this cycle.
- DataInReady  output  1  FIFO can accept a byte. Equals !full.
- SOut  output  1  serial line. Idles high.
- Busy  output  1  high while the FIFO is non-empty or a frame is in progress.
- Count  output  $clog2(Depth)+1  current FIFO occupancy, from 0 to Depth.

## Operation
- CyclesPerBit = ClockFreq/BaudRate, using truncating integer division. The bit-period counter is $clog2(CyclesPerBit) bits wide.
- Push: a byte is written on a rising edge where DataInValid && DataInReady. A push while full is ignored: no write, Count unchanged.
- FIFO: circular buffer with write and read pointers that wrap modulo Depth. Count is held in a register.
- Simultaneous push and pop in one cycle leaves Count unchanged and both pointers advance.
- Frame format: 1 start bit (0), then 8 data bits LSB first, then 1 stop bit (1).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: SOut=1. If Count!=0, pop the head byte into the shift register and go to START.
  - START: SOut=0 for CyclesPerBit cycles, then go to DATA with bit index 0.
  - DATA: SOut=shift[0] for CyclesPerBit cycles, then shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: SOut=1 for CyclesPerBit cycles. At the end, if Count!=0, pop and go directly to START with no idle gap; otherwise go to IDLE.
- SOut is driven from a register, with no combinational path from inputs.
- Busy = (state!=IDLE) || (Count!=0).
- Reset asserted at any time, including mid-frame: the state returns to IDLE immediately and asynchronously. SOut=1, pointers and Count are cleared, and the partial frame is abandoned.

## Timing
- Reset values: SOut=1, DataInReady=1, Busy=0, Count=0, state IDLE.
- Idle latency: a byte accepted on edge k while IDLE and empty is popped on edge k+1. SOut falls after edge k+1.
- Frame length: exactly 10*CyclesPerBit cycles from SOut falling to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Full condition: Count==Depth drives DataInReady=0 combinationally from the Count register. A pop on edge k makes DataInReady=1 after edge k.
- Busy falls on the same edge the FSM enters IDLE with Count==0.
- Pop happens only on entry to START. A byte pushed mid-frame waits until the current stop bit ends.

## Test plan
Use ClockFreq=800, BaudRate=100 (CyclesPerBit=8) and Depth=8 unless stated.
- Reset: deassert Reset after 3 cycles -> SOut=1, DataInReady=1, Busy=0, Count=0. Assert Reset again for 1 cycle, with no clock edge during it -> outputs return to these values immediately.
- Single byte: push 0xA5 while idle.
  - SOut falls 1 cycle after the accept edge.
  - SOut then holds 0,1,0,1,0,0,1,0,1,1, each value for 8 cycles.
  - Busy drops after 80 line cycles and Count returns to 0.
- Back-to-back: push 0x00 then 0xFF on consecutive cycles. SOut holds 0 for 72 cycles and then 1 for 8 cycles (stop bit). The next frame follows with no gap: start bit 0 for 8 cycles, 64 cycles of 1, and stop bit 1.
- Fill: hold DataInValid=1 with bytes 0x01..0x0A.
  - DataInReady drops after 9 bytes are accepted (one byte was already popped) and Count=8.
  - The extra push is ignored.
  - DataInReady rises 1 cycle after the next pop.
  - All 9 bytes appear on SOut in order.
- Reset mid-frame: assert Reset during data bit 3 of 0x3C.
  - SOut=1 and Count=0 asynchronously, and no further frame is produced.
  - After release, pushing 0x55 produces a clean frame.
- Wrap-around: push and drain 20 bytes with 0-3 random idle cycles between pushes. Every byte is transmitted in order and Count never exceeds 8.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 serial transmitter.
// Bytes enter through a ready/valid handshake and are sent LSB first at
// ClockFreq/BaudRate clocks per bit. Back-to-back frames have no idle gap.
module uart_tx_fifo #(
    parameter int ClockFreq = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int Depth     = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [7:0]               DataIn,
    input  logic                     DataInValid,
    output logic                     DataInReady,
    output logic                     SOut,
    output logic                     Busy,
    output logic [$clog2(Depth):0]   Count
);

    localparam int CyclesPerBit = ClockFreq / BaudRate;
    localparam int CntW         = (CyclesPerBit > 1) ? $clog2(CyclesPerBit) : 1;
    localparam int PtrW         = $clog2(Depth);

    localparam logic [CntW-1:0] BitLast  = CntW'(CyclesPerBit - 1);
    localparam logic [PtrW:0]   CountMax = (PtrW + 1)'(Depth);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // FIFO storage and pointers
    logic [7:0]      mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q,  count_d;

    // Transmitter state
    state_e          state_q,   state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q,   shift_d;
    logic            sout_q,    sout_d;

    logic push;
    logic pop;
    logic bit_end;

    assign DataInReady = (count_q != CountMax);
    assign push        = DataInValid && DataInReady;
    assign bit_end     = (bit_cnt_q == BitLast);

    assign SOut  = sout_q;
    assign Busy  = (state_q != IDLE) || (count_q != '0);
    assign Count = count_q;

    // Next-state for the transmitter: pop only when entering START.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        sout_d    = sout_q;
        pop       = 1'b0;

        unique case (state_q)
            IDLE: begin
                sout_d    = 1'b1;
                bit_cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    state_d = START;
                    sout_d  = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                    sout_d    = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        sout_d  = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        sout_d    = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (count_q != '0) begin
                        // Chain straight into the next frame with no idle gap.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        state_d = START;
                        sout_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        sout_d  = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                sout_d    = 1'b1;
            end
        endcase
    end

    // Next pointers and occupancy; a simultaneous push and pop keeps Count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset abandons any frame and empties the FIFO.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= 3'd0;
            sout_q    <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            sout_q    <= sout_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Data registers carry no reset; they are always loaded before use.
    always_ff @(posedge Clock) begin
        shift_q <= shift_d;
        if (push) begin
            mem_q[wr_ptr_q] <= DataIn;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed stimulus for uart_tx_fifo with a
// frame-level reference model compared against the DUT every cycle.
module tb_uart_tx_fifo;

    localparam int CF    = 800;
    localparam int BR    = 100;
    localparam int DEPTH = 8;
    localparam int CPB   = CF / BR;
    localparam int FRAME = 10 * CPB;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic       DataInValid = 1'b0;
    logic       DataInReady;
    logic       SOut;
    logic       Busy;
    logic [3:0] Count;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int max_cnt = 0;
    bit chk_en  = 1'b0;

    uart_tx_fifo #(
        .ClockFreq(CF),
        .BaudRate (BR),
        .Depth    (DEPTH)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .DataIn     (DataIn),
        .DataInValid(DataInValid),
        .DataInReady(DataInReady),
        .SOut       (SOut),
        .Busy       (Busy),
        .Count      (Count)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc++;

    // Reference model: a queue of pending bytes plus the position inside the
    // frame currently on the line.
    logic [7:0] mq[$];
    bit         m_act = 1'b0;
    int         m_t   = 0;
    logic [7:0] m_cur = 8'h00;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mq.delete();
            m_act = 1'b0;
            m_t   = 0;
        end else begin : model_step
            int pre;
            bit dpush;
            bit dpop;
            pre   = mq.size();
            dpush = DataInValid && (pre != DEPTH);
            dpop  = (pre != 0) && (!m_act || m_t == FRAME - 1);
            if (dpop) begin
                m_cur = mq.pop_front();
                m_act = 1'b1;
                m_t   = 0;
            end else if (m_act) begin
                if (m_t == FRAME - 1) m_act = 1'b0;
                else m_t++;
            end
            if (dpush) mq.push_back(DataIn);
        end
    end

    function automatic logic model_sout();
        int b;
        if (!m_act) return 1'b1;
        b = m_t / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_cur[b-1];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge Clock) begin
        if (chk_en) begin
            chk("sout",  32'(SOut),        32'(model_sout()));
            chk("ready", 32'(DataInReady), 32'(mq.size() != DEPTH));
            chk("busy",  32'(Busy),        32'(m_act || mq.size() != 0));
            chk("count", 32'(Count),       32'(mq.size()));
            if (int'(Count) > max_cnt) max_cnt = int'(Count);
        end
    end

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        DataIn      = b;
        DataInValid = 1'b1;
        while (!DataInReady && n < 5000) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 5000) chk("push_timeout", 32'(DataInReady), 32'd1);
        @(negedge Clock);
        DataInValid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (Busy && n < limit) begin
            @(negedge Clock);
            n++;
        end
        if (n >= limit) chk("idle_timeout", 32'(Busy), 32'd0);
    endtask

    task automatic run_len(input logic v, output int n);
        n = 0;
        while (SOut === v && n < 1000) begin
            n++;
            @(negedge Clock);
        end
    endtask

    initial begin
        logic [9:0] pat;
        int         t0;
        int         len;

        // Reset
        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        Reset  = 1'b1;
        chk_en = 1'b1;
        chk("rst_sout",  32'(SOut),        32'd1);
        chk("rst_ready", 32'(DataInReady), 32'd1);
        chk("rst_busy",  32'(Busy),        32'd0);
        chk("rst_count", 32'(Count),       32'd0);
        @(negedge Clock);

        // Single byte 0xA5
        pat = 10'b1101001010;
        push(8'hA5);
        chk("a5_before_fall", 32'(SOut), 32'd1);
        @(negedge Clock);
        chk("a5_fall", 32'(SOut), 32'd0);
        t0 = cyc;
        repeat (4) @(negedge Clock);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("a5_bit%0d", i), 32'(SOut), 32'(pat[i]));
            if (i < 9) repeat (CPB) @(negedge Clock);
        end
        wait_idle(200);
        chk("a5_busy_len", 32'(cyc - t0), 32'(FRAME));
        chk("a5_count",    32'(Count),    32'd0);
        repeat (3) @(negedge Clock);

        // Back-to-back 0x00 then 0xFF
        push(8'h00);
        push(8'hFF);
        run_len(1'b0, len);
        chk("b2b_zeros", 32'(len), 32'd72);
        run_len(1'b1, len);
        chk("b2b_stop", 32'(len), 32'd8);
        t0 = cyc;
        run_len(1'b0, len);
        chk("b2b_start2", 32'(len), 32'd8);
        wait_idle(400);
        chk("b2b_frame2_len", 32'(cyc - t0), 32'(FRAME));
        repeat (2) @(negedge Clock);

        // Fill the FIFO: nine bytes accepted, tenth refused
        for (int b = 1; b <= 9; b++) push(8'(b));
        chk("fill_count", 32'(Count),       32'd8);
        chk("fill_ready", 32'(DataInReady), 32'd0);
        DataIn      = 8'h0A;
        DataInValid = 1'b1;
        repeat (5) @(negedge Clock);
        DataInValid = 1'b0;
        chk("fill_ignored", 32'(Count), 32'd8);
        wait_idle(12 * FRAME);
        repeat (2) @(negedge Clock);

        // Reset in the middle of data bit 3 of 0x3C, with a second byte queued
        push(8'h3C);
        push(8'h99);
        repeat (35) @(negedge Clock);
        #1 Reset = 1'b0;
        #1;
        chk("midrst_sout",  32'(SOut),        32'd1);
        chk("midrst_count", 32'(Count),       32'd0);
        chk("midrst_busy",  32'(Busy),        32'd0);
        chk("midrst_ready", 32'(DataInReady), 32'd1);
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (100) @(negedge Clock);
        chk("midrst_quiet_busy", 32'(Busy), 32'd0);

        // Reset pulse between clock edges while a byte is queued
        push(8'h55);
        #1 Reset = 1'b0;
        #1;
        chk("pulse_sout",  32'(SOut),  32'd1);
        chk("pulse_count", 32'(Count), 32'd0);
        chk("pulse_busy",  32'(Busy),  32'd0);
        #1 Reset = 1'b1;
        @(negedge Clock);
        push(8'h55);
        wait_idle(200);
        repeat (2) @(negedge Clock);

        // Wrap-around with random bytes and random gaps
        for (int i = 0; i < 20; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge Clock);
        end
        wait_idle(25 * FRAME);
        chk("wrap_count",     32'(Count),   32'd0);
        chk("wrap_max_count", 32'(max_cnt), 32'(DEPTH));
        repeat (4) @(negedge Clock);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
